// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: recovers pixel coordinates from an incoming HS/VS/RGB stream and tracks timing lock.
// Ports: in_clock/in_reset (sync, active-low), in_pixel_stb qualifies every sample,
//        in_hsync/in_vsync active-low syncs, in_r/g/b colour in; out_x/out_y/out_r/g/b pixel
//        out, out_pixel_valid/out_frame_start one-clock pulses, out_locked, out_err_count (saturating).
module vga_sync_decoder #(
    parameter int H_SYNC      = 96,
    parameter int H_BP        = 48,
    parameter int H_ACTIVE    = 640,
    parameter int H_TOTAL     = 800,
    parameter int V_SYNC      = 2,
    parameter int V_BP        = 33,
    parameter int V_ACTIVE    = 480,
    parameter int V_TOTAL     = 525,
    parameter int LOCK_FRAMES = 2
) (
    input  logic       in_clock,
    input  logic       in_reset,
    input  logic       in_pixel_stb,
    input  logic       in_hsync,
    input  logic       in_vsync,
    input  logic [3:0] in_r,
    input  logic [3:0] in_g,
    input  logic [3:0] in_b,
    output logic [9:0] out_x,
    output logic [8:0] out_y,
    output logic [3:0] out_r,
    output logic [3:0] out_g,
    output logic [3:0] out_b,
    output logic       out_pixel_valid,
    output logic       out_frame_start,
    output logic       out_locked,
    output logic [7:0] out_err_count
);
    localparam logic [9:0] H_END  = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_END  = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_SW   = 10'(H_SYNC);
    localparam logic [9:0] HA0    = 10'(H_SYNC + H_BP);
    localparam logic [9:0] HA1    = 10'(H_SYNC + H_BP + H_ACTIVE);
    localparam logic [9:0] VA0    = 10'(V_SYNC + V_BP);
    localparam logic [9:0] VA1    = 10'(V_SYNC + V_BP + V_ACTIVE);
    localparam logic [7:0] GF_END = 8'(LOCK_FRAMES);

    typedef enum logic [1:0] {SEARCH, LINE, FRAME, LOCKED} state_t;

    state_t     state, state_nx;
    logic [7:0] gf, gf_nx;
    logic [9:0] hcnt, vcnt, hcnt_nx, vcnt_nx;
    logic       prev_hs, prev_vs, vs_pend;
    logic       hs_fall, hs_rise, vs_fall, f_start, err, h_act, v_act;

    assign hs_fall = prev_hs & ~in_hsync;
    assign hs_rise = ~prev_hs & in_hsync;
    assign vs_fall = prev_vs & ~in_vsync;
    // a pending (or simultaneous) vsync fall is only acted on at a line start
    assign f_start = hs_fall & (vs_pend | vs_fall);
    assign hcnt_nx = hs_fall ? '0 : (&hcnt) ? hcnt : hcnt + 10'd1;
    assign vcnt_nx = f_start ? '0 : hs_fall ? vcnt + 10'd1 : vcnt;
    // sync width is judged on the post-update count, i.e. the strobe index within the line;
    // the frame-length check is skipped in LINE because that frame started unaligned
    assign err = (state != SEARCH) &&
                 ((hs_fall && hcnt != H_END) ||
                  (hs_rise && hcnt_nx != H_SW) ||
                  (!hs_fall && hcnt == 10'd1022) ||
                  (state != LINE && f_start && vcnt != V_END));
    assign h_act = hcnt_nx >= HA0 && hcnt_nx < HA1;
    assign v_act = vcnt_nx >= VA0 && vcnt_nx < VA1;

    always_comb begin
        state_nx = state;
        gf_nx    = gf;
        if (err) state_nx = SEARCH;
        else if (state == SEARCH && hs_fall) state_nx = LINE;
        else if (state == LINE && f_start) begin
            state_nx = FRAME;
            gf_nx    = '0;
        end else if (state == FRAME && f_start) begin
            gf_nx    = gf + 8'd1;
            state_nx = (gf_nx == GF_END) ? LOCKED : FRAME;
        end
    end

    always_ff @(posedge in_clock) begin
        if (!in_reset) begin
            state           <= SEARCH;
            gf              <= '0;
            hcnt            <= '0;
            vcnt            <= '0;
            prev_hs         <= 1'b1;
            prev_vs         <= 1'b1;
            vs_pend         <= 1'b0;
            out_x           <= '0;
            out_y           <= '0;
            out_r           <= '0;
            out_g           <= '0;
            out_b           <= '0;
            out_pixel_valid <= 1'b0;
            out_frame_start <= 1'b0;
            out_locked      <= 1'b0;
            out_err_count   <= '0;
        end else begin
            out_pixel_valid <= 1'b0;
            out_frame_start <= 1'b0;
            if (in_pixel_stb) begin
                state           <= state_nx;
                gf              <= gf_nx;
                hcnt            <= hcnt_nx;
                vcnt            <= vcnt_nx;
                prev_hs         <= in_hsync;
                prev_vs         <= in_vsync;
                vs_pend         <= ~f_start & (vs_pend | vs_fall);
                out_err_count   <= (err && out_err_count != 8'hFF) ? out_err_count + 8'd1 : out_err_count;
                out_locked      <= state_nx == LOCKED;
                out_pixel_valid <= state_nx == LOCKED && h_act && v_act;
                out_frame_start <= f_start;
                out_x           <= hcnt_nx - HA0;
                out_y           <= 9'(vcnt_nx - VA0);
                out_r           <= in_r;
                out_g           <= in_g;
                out_b           <= in_b;
            end
        end
    end
endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: randomized/directed stream bench for vga_sync_decoder with a sample-level reference model.
`timescale 1ns/1ps
module tb_vga_sync_decoder;
    localparam int HS = 4, HBP = 3, HA = 10, HT = 20;
    localparam int VS = 2, VBP = 2, VA = 6, VT = 12, LF = 2;

    logic       clk = 0, rst_n = 0, stb = 0, hs = 1, vs = 1;
    logic [3:0] ir = 0, ig = 0, ib = 0;
    logic [9:0] out_x;
    logic [8:0] out_y;
    logic [3:0] out_r, out_g, out_b;
    logic       out_pixel_valid, out_frame_start, out_locked;
    logic [7:0] out_err_count;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_SYNC(HS), .H_BP(HBP), .H_ACTIVE(HA), .H_TOTAL(HT),
        .V_SYNC(VS), .V_BP(VBP), .V_ACTIVE(VA), .V_TOTAL(VT), .LOCK_FRAMES(LF)
    ) dut (
        .in_clock(clk), .in_reset(rst_n), .in_pixel_stb(stb),
        .in_hsync(hs), .in_vsync(vs), .in_r(ir), .in_g(ig), .in_b(ib),
        .out_x(out_x), .out_y(out_y), .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_pixel_valid(out_pixel_valid), .out_frame_start(out_frame_start),
        .out_locked(out_locked), .out_err_count(out_err_count)
    );

    int n_vec = 0, n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model. m_stage: 0 = hunting, 1 = line aligned, 2+n = frame aligned with n good frames.
    int  m_h, m_v, m_stage, m_err, e_x, e_y;
    bit  m_phs, m_pvs, m_pend, e_valid, e_fs, e_locked;

    function automatic void model_reset();
        m_h = 0; m_v = 0; m_stage = 0; m_err = 0;
        m_phs = 1; m_pvs = 1; m_pend = 0;
    endfunction

    function automatic void model_step(input bit h_in, input bit v_in);
        bit fall, rise, vfall, fst, bad;
        int nh, nv;
        fall  = m_phs && !h_in;
        rise  = !m_phs && h_in;
        vfall = m_pvs && !v_in;
        nh    = fall ? 0 : (m_h + 1 > 1023 ? 1023 : m_h + 1);
        fst   = fall && (m_pend || vfall);
        nv    = fst ? 0 : fall ? (m_v + 1) % 1024 : m_v;
        bad   = m_stage > 0 && ((fall && m_h != HT - 1) || (rise && nh != HS) || (!fall && nh == 1023 && m_h != 1023));
        if (m_stage >= 2 && fst && m_v != VT - 1) bad = 1;
        if (bad) begin
            m_stage = 0;
            if (m_err < 255) m_err++;
        end else if ((m_stage == 0 && fall) || (m_stage > 0 && m_stage < 2 + LF && fst)) m_stage++;
        m_pend   = !fst && (m_pend || vfall);
        e_locked = m_stage == 2 + LF;
        e_fs     = fst;
        e_valid  = e_locked && nh >= HS + HBP && nh < HS + HBP + HA && nv >= VS + VBP && nv < VS + VBP + VA;
        e_x      = (nh - HS - HBP) & 1023;
        e_y      = (nv - VS - VBP) & 511;
        m_h = nh; m_v = nv; m_phs = h_in; m_pvs = v_in;
    endfunction

    int smp = 0, rise_at = -1, px_cnt = 0, first_x, first_y, last_x, last_y;
    bit last_vs = 1;

    task automatic send(input bit h_in, input bit v_in, input logic [3:0] r, input logic [3:0] g, input logic [3:0] b);
        @(negedge clk);
        stb = 1; hs = h_in; vs = v_in; ir = r; ig = g; ib = b;
        model_step(h_in, v_in);
        @(posedge clk); #1;
        chk("locked", out_locked, e_locked);
        chk("err_count", out_err_count, m_err);
        chk("valid", out_pixel_valid, e_valid);
        chk("frame_start", out_frame_start, e_fs);
        if (e_valid) chk("pixel", {out_x, out_y, out_r, out_g, out_b}, {e_x[9:0], e_y[8:0], r, g, b});
        if (out_locked && rise_at < 0) rise_at = smp;
        if (out_pixel_valid) begin
            if (px_cnt == 0) begin first_x = out_x; first_y = out_y; end
            px_cnt++;
            last_x = out_x; last_y = out_y;
        end
        smp++;
        @(negedge clk);
        stb = 0;
        @(posedge clk); #1;
        chk("pulse_width", {out_pixel_valid, out_frame_start}, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 0; stb = 1; hs = 1'($urandom); vs = 1'($urandom);
        ir = 4'($urandom); ig = 4'($urandom); ib = 4'($urandom);
        @(posedge clk); #1;
        chk("reset_pixel", {out_x, out_y, out_r, out_g, out_b}, 0);
        chk("reset_flags", {out_pixel_valid, out_frame_start, out_locked, out_err_count}, 0);
        model_reset();
        @(negedge clk);
        rst_n = 1; stb = 0;
    endtask

    // one line of the ramp pattern; vo delays the vsync level change into the line
    task automatic send_line(input int v, input int h0, input int len, input int hw, input int vo);
        int x, y;
        for (int h = h0; h < len; h++) begin
            x = h - HS - HBP;
            y = v - VS - VBP;
            send(h >= hw, (h < vo) ? last_vs : !(v < VS), 4'(x), 4'(y), 4'($urandom));
        end
        last_vs = !(v < VS);
    endtask

    task automatic send_lines(input int v0, input int n);
        for (int i = 0; i < n; i++) send_line((v0 + i) % VT, 0, HT, HS, 0);
    endtask

    // ideal stream from line v0 until the end of the first locked frame
    task automatic run_lock(input int v0);
        int base;
        base = smp;
        rise_at = -1;
        send_lines(v0, (VT - v0) + 2 * VT);
        px_cnt = 0;
        send_lines(0, VT);
        chk("lock_time", rise_at - base, (VT - v0) * HT + 2 * VT * HT);
        chk("frame_pixels", px_cnt, HA * VA);
        chk("first_x", first_x, 0);
        chk("first_y", first_y, 0);
        chk("last_x", last_x, HA - 1);
        chk("last_y", last_y, VA - 1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, v, len, hw, vo;
        model_reset();
        repeat (3) @(posedge clk);
        do_reset();
        run_lock(VT - 3);

        send_lines(0, 5);
        chk("locked_before_short", out_locked, 1);
        e0 = out_err_count;
        send_line(5, 0, HT - 1, HS, 0);
        send_line(6, 0, 1, HS, 0);
        chk("short_err", out_err_count, e0 + 1);
        chk("short_unlock", out_locked, 0);
        send_line(6, 1, HT, HS, 0);
        send_lines(7, (VT - 7) + 3 * VT);
        chk("relock", out_locked, 1);

        e0 = out_err_count;
        send_line(0, 0, 1100 + HS, HS, 0);
        chk("hold_err", out_err_count, e0 + 1);
        chk("hold_unlock", out_locked, 0);

        for (int i = 0; i < 22 * VT; i++) send_line(i % VT, 0, HT, HS + 1, 0);
        chk("err_saturate", out_err_count, 255);

        send_lines(0, 4 * VT);
        chk("locked_pre_reset", out_locked, 1);
        send_lines(0, 5);
        do_reset();
        run_lock(5);

        v = 0;
        repeat (300) begin
            len = ($urandom % 40 == 0) ? HT - 1 + int'($urandom % 3) : HT;
            hw  = ($urandom % 40 == 0) ? HS - 1 + int'($urandom % 3) : HS;
            vo  = ($urandom % 10 == 0) ? int'($urandom % HT) : 0;
            if ($urandom % 150 == 0) do_reset();
            send_line(v, 0, len, hw, vo);
            v = ($urandom % 200 == 0) ? int'($urandom % VT) : (v + 1) % VT;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
